// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: data, request and status bundle for sync_fifo_flags.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_flags_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic             clr_err;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             almost_full;
    logic             almost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wdata, winc, rinc, clr_err,
        input  rdata, wfull, rempty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, clr_err,
        output rdata, wfull, rempty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise
// rdata is registered and updated on each accepted read.
module sync_fifo_flags #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_flags_if.slave  bus
);
    localparam int             DEPTH      = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_CNT  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE+1)'(AFULL_LVL);
    localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE+1)'(AEMPTY_LVL);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;
    logic [ASIZE:0]   cnt;
    logic             overflow_q;
    logic             underflow_q;
    logic             wfull;
    logic             rempty;
    logic             do_write;
    logic             do_read;

    // Flags come straight from the registered count; requests are qualified
    // against those pre-edge flags.
    assign wfull    = (cnt == DEPTH_CNT);
    assign rempty   = (cnt == '0);
    assign do_write = bus.winc && !wfull;
    assign do_read  = bus.rinc && !rempty;

    // Storage array: accepted writes only.
    // NOTE: the array has no reset; rst only discards it by clearing the
    // pointers and count, so it maps onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wptr] <= bus.wdata;
        end
    end

    // Pointers and occupancy count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_write) wptr <= wptr + 1'b1;
            if (do_read)  rptr <= rptr + 1'b1;
            case ({do_write, do_read})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags; a set condition on the clearing edge wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.winc && wfull)  overflow_q <= 1'b1;
            else if (bus.clr_err)   overflow_q <= 1'b0;
            if (bus.rinc && rempty) underflow_q <= 1'b1;
            else if (bus.clr_err)   underflow_q <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word shown combinationally; zero while nothing is stored.
    assign bus.rdata = rempty ? '0 : mem[rptr];
`else
    logic [DSIZE-1:0] rdata_q;

    // Registered read: load the head word on each accepted read, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (do_read) begin
            rdata_q <= mem[rptr];
        end
    end

    assign bus.rdata = rdata_q;
`endif

    assign bus.wfull        = wfull;
    assign bus.rempty       = rempty;
    assign bus.almost_full  = (cnt >= AFULL_CNT);
    assign bus.almost_empty = (cnt <= AEMPTY_CNT);
    assign bus.count        = cnt;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed bench for sync_fifo_flags with a data
// scoreboard and a reference occupancy/flag model. Works in both the
// registered-read and SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo_flags;
    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;
    localparam int AEMPT = 2;

    logic clk;
    logic rst;

    sync_fifo_flags_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    sync_fifo_flags #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] sb [$];
    int               m_cnt;
    logic             m_ovf;
    logic             m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        check("count",        32'(bus.count),        32'(m_cnt));
        check("wfull",        32'(bus.wfull),        32'(m_cnt == DEPTH));
        check("rempty",       32'(bus.rempty),       32'(m_cnt == 0));
        check("almost_full",  32'(bus.almost_full),  32'(m_cnt >= AFULL));
        check("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= AEMPT));
        check("overflow",     32'(bus.overflow),     32'(m_ovf));
        check("underflow",    32'(bus.underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (m_cnt != 0) check("fwft_head", 32'(bus.rdata), 32'(sb[0]));
        else            check("fwft_empty_rdata", 32'(bus.rdata), 32'd0);
`endif
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge state.
    task automatic cycle(input logic w, input logic [DSIZE-1:0] wd,
                         input logic r, input logic clr);
        logic             acc_w;
        logic             acc_r;
        logic [DSIZE-1:0] exp_d;
        @(negedge clk);
        bus.winc    = w;
        bus.wdata   = wd;
        bus.rinc    = r;
        bus.clr_err = clr;
        acc_w = w && (m_cnt != DEPTH);
        acc_r = r && (m_cnt != 0);
        exp_d = '0;
        if (acc_r) exp_d = sb.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
        if (acc_r) check("fwft_pop_data", 32'(bus.rdata), 32'(exp_d));
`endif
        if (acc_w) sb.push_back(wd);
        if (w && m_cnt == DEPTH) m_ovf = 1'b1;
        else if (clr)            m_ovf = 1'b0;
        if (r && m_cnt == 0)     m_udf = 1'b1;
        else if (clr)            m_udf = 1'b0;
        m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
        @(posedge clk);
        #1;
`ifndef SYNC_FIFO_FWFT_EN
        if (acc_r) check("read_data", 32'(bus.rdata), 32'(exp_d));
`endif
        check_status();
        bus.winc    = 1'b0;
        bus.rinc    = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.winc = 1'b1;  // requests on the reset edge must be ignored
        bus.rinc = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check("reset_rdata", 32'(bus.rdata), 32'd0);
        check_status();
        @(negedge clk);
        rst = 1'b0;
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
    endtask

    // Watchdog: the sequence is fixed-length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        bus.clr_err = 1'b0;
        bus.wdata = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Fill 0x01..0x10: count ramps, almost_empty falls at 3,
        // almost_full rises at 14, wfull at 16.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);

        // Write while full: rejected, overflow set.
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);

        // Drain: 0x01..0x10 in order, 0xAA never appears.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);  // clear overflow

        // Wrap-around with 5 words in flight.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 5; i < 45; i++) begin
            cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
            check("steady_count", 32'(bus.count), 32'd5);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Empty, write+read together: write taken, read rejected, underflow.
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);   // returns 0x55
        cycle(1'b0, '0, 1'b1, 1'b1);   // underflow set and clear together: set wins
        cycle(1'b0, '0, 1'b0, 1'b1);   // clear, count unaffected

        // Full, write+read together: read taken, write rejected.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);

        // Reset with 8 words stored.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        do_reset();

        // Post-reset sanity: old contents gone, new data flows.
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It is the same-clock-domain successor to the team's dual-clock FIFO. It serves paths where producer and consumer share one clock and need level visibility rather than just full/empty. Data width, depth and threshold levels are parameters. First-word-fall-through read mode is a compile-time option.

## Interface
Parameters:
- DSIZE, 8, data word width in bits
- ASIZE, 4, address width; depth DEPTH = 2^ASIZE
- AFULL_LVL, 14, almost_full asserts when count >= AFULL_LVL (legal range 1..DEPTH)
- AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL (legal range 0..DEPTH-1)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wdata  in  DSIZE  write data
- winc  in  1  write request
- rinc  in  1  read request
- clr_err  in  1  synchronous clear of overflow/underflow
- rdata  out  DSIZE  read data
- wfull  out  1  count == DEPTH
- rempty  out  1  count == 0
- almost_full  out  1  count >= AFULL_LVL
- almost_empty  out  1  count <= AEMPTY_LVL
- count  out  ASIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage is a DEPTH x DSIZE register array.
- Write pointer wptr and read pointer rptr are ASIZE bits wide and wrap modulo DEPTH with natural binary rollover.
- Write is accepted iff winc && !wfull, with wfull sampled as registered before the edge. An accepted write stores wdata at mem[wptr] and increments wptr.
- Read is accepted iff rinc && !rempty. An accepted read increments rptr.
- Count update per edge:
  - +1 for a write alone.
  - -1 for a read alone.
  - Unchanged when both are accepted or neither is.
- Simultaneous winc && rinc:
  - When full: the read is accepted and the write is rejected. count becomes DEPTH-1 and overflow is set.
  - When empty: the write is accepted and the read is rejected. count becomes 1 and underflow is set.
  - Otherwise both are accepted.
- overflow is set on winc && wfull. underflow is set on rinc && rempty. Both stay set until clr_err or rst.
- If a set condition and clr_err occur on the same edge, set wins.
- Rejected operations never modify the memory, the pointers or count.
- rst clears wptr, rptr, count, overflow, underflow and rdata. Memory contents are not cleared.
- rst mid-operation discards all stored data. Requests on the reset edge are ignored.
- Reset values:
  - rdata = 0, count = 0, rempty = 1, wfull = 0.
  - almost_empty = 1, almost_full = (AFULL_LVL == 0), which is 0 for legal values.
  - overflow = underflow = 0.

## Timing
- All flags and count are derived combinationally from registered count. They reflect an operation in the cycle after its accepting edge.
- Default (registered read):
  - rdata <= mem[rptr] on each accepted-read edge, so data is valid in the cycle after rinc is accepted.
  - rdata holds its value when no read is accepted.
- Write-to-read latency: a word written at edge N is readable (rempty = 0) from edge N onward. The earliest accepting read edge is N+1.
- Full throughput: one write and one read per cycle, sustained with no bubbles.

## Configuration
- SYNC_FIFO_FWFT_EN defined: rdata = mem[rptr] combinationally whenever rempty = 0.
  - The head word is visible with no read request.
  - An accepted rinc pops the word, and the next word appears in the following cycle.
  - rdata = 0 while rempty.
  - Word written at edge N appears on rdata in cycle N+1.
- SYNC_FIFO_FWFT_EN undefined: registered-read behaviour as in Timing.
- Flags, count and error logic are identical in both modes.

## Test plan
- Reset, then write 0x01..0x10 (16 words) at one per cycle:
  - count steps 1..16.
  - almost_full rises at count 14 and wfull rises at 16.
  - almost_empty falls at count 3.
- From full, assert winc with wdata = 0xAA for 1 cycle:
  - count stays 16 and overflow = 1.
  - The subsequent 16 reads return 0x01..0x10 in order, with no 0xAA.
- Wrap-around: run 40 single write/read pairs with an offset of 5 words in flight:
  - Read data matches the write order.
  - count stays 5 throughout the steady state.
- When empty, assert winc = rinc = 1 with wdata = 0x55:
  - count becomes 1 and underflow = 1.
  - The next read returns 0x55.
  - clr_err then clears underflow while count is unaffected.
- When full, assert winc = rinc = 1:
  - count becomes 15, overflow = 1, and rdata returns the head word.
  - Assert rst with 8 words stored: the next cycle count = 0, rempty = 1, rdata = 0, and flags = 0.
- Run the first three scenarios with SYNC_FIFO_FWFT_EN defined:
  - rdata = 0x01 one cycle after the first write, with no rinc.
  - Each pop exposes the next value in the following cycle.
